mult_seq_core: RTL

//  Responder side of the mult req/ack protocol: a sequential signed 16x16 multiplier with even-parity checking.
//  It accepts operands on req with a one-cycle ack, computes the product by iterative shift-add, and presents

---
 rtl/mult_seq_core.sv | 79 +++++++
 1 files changed

// File: rtl/mult_seq_core.sv
// mult_seq_core: sequential signed WIDTHxWIDTH shift-add multiplier with req/ack handshake and even-parity checking
module mult_seq_core #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     arg_a,
  input  logic [WIDTH-1:0]     arg_b,
  input  logic                 arg_a_parity,
  input  logic                 arg_b_parity,
  input  logic                 req,
  output logic                 ack,
  output logic [2*WIDTH-1:0]   result,
  output logic                 result_parity,
  output logic                 result_rdy,
  output logic                 arg_parity_error
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH:0]       r_ma, r_mb, w_ma, w_mb;
  logic [2*WIDTH-1:0]   r_acc, w_pp, w_res;
  logic [CW-1:0]        r_cnt;
  logic                 r_sign, r_perr, w_perr, w_last;
  // magnitudes are one bit wider so that -2^(WIDTH-1) stays representable
  function automatic logic [WIDTH:0] mag(input logic [WIDTH-1:0] v);
    mag = v[WIDTH-1] ? -{v[WIDTH-1], v} : {v[WIDTH-1], v};
  endfunction
  always_comb begin
    w_ma   = mag(arg_a);
    w_mb   = mag(arg_b);
    w_perr = ((^arg_a) != arg_a_parity) | ((^arg_b) != arg_b_parity);
    w_last = r_cnt == CW'(WIDTH - 1);
    w_pp   = r_mb[0] ? ({{(WIDTH-1){1'b0}}, r_ma} << r_cnt) : '0;
    w_res  = r_sign ? -r_acc : r_acc;
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = req ? (w_perr ? DONE : BUSY) : IDLE;
      BUSY:    w_next = w_last ? DONE : BUSY;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      ack              <= 1'b0;
      result_rdy       <= 1'b0;
      result           <= '0;
      result_parity    <= 1'b0;
      arg_parity_error <= 1'b0;
      r_ma             <= '0;
      r_mb             <= '0;
      r_acc            <= '0;
      r_cnt            <= '0;
      r_sign           <= 1'b0;
      r_perr           <= 1'b0;
    end else begin
      ack        <= (r_state == IDLE) && req;
      result_rdy <= r_state == DONE;
      if (r_state == IDLE && req) begin
        r_ma   <= w_ma;
        r_mb   <= w_mb;
        r_sign <= arg_a[WIDTH-1] ^ arg_b[WIDTH-1];
        r_perr <= w_perr;
        r_acc  <= '0;
        r_cnt  <= '0;
      end else if (r_state == BUSY) begin
        r_acc <= r_acc + w_pp;
        r_mb  <= r_mb >> 1;
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == DONE) begin
        result           <= r_perr ? '0 : w_res;
        result_parity    <= r_perr ? 1'b0 : ^w_res;
        arg_parity_error <= r_perr;
      end
    end
  end
endmodule
